// File: rtl/idli_sqi_resp_m.sv
// SQI responder: decodes a 2-nibble command and 4-nibble address, then streams
// 16-bit words to or from a synchronous memory, LS nibble first.
module idli_sqi_resp_m (
  input  logic        i_resp_sck,
  input  logic        i_ctrl_rst_n,
  input  logic        i_resp_cs_n,
  input  logic [3:0]  i_resp_sio,
  output logic [3:0]  o_resp_sio,
  output logic        o_resp_sio_oe,
  output logic [15:0] o_resp_mem_addr,
  output logic        o_resp_mem_rd_en,
  input  logic [15:0] i_resp_mem_rdata,
  output logic        o_resp_mem_wr_en,
  output logic [15:0] o_resp_mem_wdata
);

  typedef enum logic [2:0] {
    CMD    = 3'd0,
    ADDR   = 3'd1,
    DUMMY  = 3'd2,
    RDATA  = 3'd3,
    WDATA  = 3'd4,
    IGNORE = 3'd5
  } state_t;

  state_t      state_q;
  logic [1:0]  cnt_q;
  logic        is_rd_q;
  logic [3:0]  cmd_hi_q;
  logic [15:0] addr_q;
  logic [11:0] wcap_q;
  logic [15:0] rshift_q;
  logic [3:0]  sio_q;
  logic        oe_q;

  // Strobes are combinational so the memory sees them on the same edge that
  // the responder consumes the corresponding nibble.
  assign o_resp_mem_rd_en = ~i_resp_cs_n &
                            (((state_q == DUMMY) && (cnt_q == 2'd0)) ||
                             ((state_q == RDATA) && (cnt_q == 2'd2)));
  assign o_resp_mem_wr_en = ~i_resp_cs_n & (state_q == WDATA) & (cnt_q == 2'd3);
  assign o_resp_mem_wdata = {i_resp_sio, wcap_q};
  assign o_resp_mem_addr  = addr_q;
  assign o_resp_sio       = sio_q;
  assign o_resp_sio_oe    = oe_q & ~i_resp_cs_n;

  always_ff @(posedge i_resp_sck or negedge i_ctrl_rst_n) begin
    if (!i_ctrl_rst_n) begin
      state_q  <= CMD;
      cnt_q    <= '0;
      is_rd_q  <= 1'b0;
      cmd_hi_q <= '0;
      addr_q   <= '0;
      wcap_q   <= '0;
      rshift_q <= '0;
    end else if (i_resp_cs_n) begin
      state_q <= CMD;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_q + 2'd1;
      case (state_q)
        CMD: begin
          cmd_hi_q <= i_resp_sio;
          if (cnt_q == 2'd1) begin
            cnt_q <= '0;
            case ({cmd_hi_q, i_resp_sio})
              8'h02: begin
                state_q <= ADDR;
                is_rd_q <= 1'b0;
              end
              8'h03: begin
                state_q <= ADDR;
                is_rd_q <= 1'b1;
              end
              default: state_q <= IGNORE;
            endcase
          end
        end
        ADDR: begin
          addr_q <= {addr_q[11:0], i_resp_sio};
          if (cnt_q == 2'd3) state_q <= is_rd_q ? DUMMY : WDATA;
        end
        DUMMY: begin
          if (cnt_q == 2'd1) begin
            rshift_q <= i_resp_mem_rdata;
            addr_q   <= addr_q + 16'd1;
            state_q  <= RDATA;
            cnt_q    <= '0;
          end
        end
        RDATA: begin
          // Reload on the 4th nibble so the next word follows with no gap.
          if (cnt_q == 2'd3) begin
            rshift_q <= i_resp_mem_rdata;
            addr_q   <= addr_q + 16'd1;
          end else begin
            rshift_q <= {4'h0, rshift_q[15:4]};
          end
        end
        WDATA: begin
          wcap_q <= {i_resp_sio, wcap_q[11:4]};
          if (cnt_q == 2'd3) addr_q <= addr_q + 16'd1;
        end
        IGNORE: ;
        default: state_q <= CMD;
      endcase
    end
  end

  always_ff @(negedge i_resp_sck or negedge i_ctrl_rst_n) begin
    if (!i_ctrl_rst_n) begin
      sio_q <= '0;
      oe_q  <= 1'b0;
    end else if (state_q == RDATA) begin
      sio_q <= rshift_q[3:0];
      oe_q  <= 1'b1;
    end else begin
      oe_q  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_idli_sqi_resp_m.sv
// Bench for idli_sqi_resp_m: per-edge transaction model built from command,
// address and word lists, compared against strobes and read nibbles.
module tb_idli_sqi_resp_m;

  logic        sck = 1'b0;
  logic        rst_n;
  logic        cs_n;
  logic [3:0]  sio_in;
  logic [3:0]  sio_out;
  logic        oe;
  logic [15:0] addr;
  logic        rd_en;
  logic [15:0] rdata;
  logic        wr_en;
  logic [15:0] wdata;

  always #5 sck = ~sck;

  idli_sqi_resp_m dut (
    .i_resp_sck       (sck),
    .i_ctrl_rst_n     (rst_n),
    .i_resp_cs_n      (cs_n),
    .i_resp_sio       (sio_in),
    .o_resp_sio       (sio_out),
    .o_resp_sio_oe    (oe),
    .o_resp_mem_addr  (addr),
    .o_resp_mem_rd_en (rd_en),
    .i_resp_mem_rdata (rdata),
    .o_resp_mem_wr_en (wr_en),
    .o_resp_mem_wdata (wdata)
  );

  typedef struct packed {
    logic        csn;
    logic [3:0]  nib;
    logic        wr;
    logic [15:0] wa;
    logic [15:0] wd;
    logic        rd;
    logic [15:0] ra;
    logic        oe;
    logic [3:0]  sio;
    logic        ca;
    logic [15:0] a;
  } step_t;

  step_t       steps[$];
  step_t       obs[$];
  logic [15:0] mem [0:65535];
  int          total = 0;
  int          bad = 0;

  function automatic step_t blank();
    step_t s;
    s = '0;
    s.nib = 4'($urandom);
    return s;
  endfunction

  function automatic void add_cmd(input logic [7:0] c);
    step_t s;
    s = blank(); s.nib = c[7:4]; steps.push_back(s);
    s = blank(); s.nib = c[3:0]; steps.push_back(s);
  endfunction

  function automatic void add_addr(input logic [15:0] a);
    step_t s;
    for (int unsigned i = 0; i < 4; i++) begin
      s = blank();
      s.nib = 4'(a >> (12 - 4 * i));
      steps.push_back(s);
    end
  endfunction

  function automatic void add_write_word(input logic [15:0] a, input logic [15:0] w);
    step_t s;
    for (int unsigned j = 0; j < 4; j++) begin
      s = blank();
      s.nib = 4'(w >> (4 * j));
      if (j == 3) begin
        s.wr = 1'b1; s.wa = a; s.wd = w;
      end
      steps.push_back(s);
    end
  endfunction

  // Two dummy edges (first requests word 0), then words stream LS nibble first;
  // each word's 3rd nibble edge requests the following word.
  function automatic void add_read(input logic [15:0] a, input int unsigned n);
    step_t s;
    logic [15:0] w;
    s = blank(); s.rd = 1'b1; s.ra = a; steps.push_back(s);
    s = blank(); steps.push_back(s);
    for (int unsigned j = 0; j < 4 * n; j++) begin
      s = blank();
      w = mem[a + 16'(j / 4)];
      s.oe = 1'b1;
      s.sio = 4'(w >> (4 * (j % 4)));
      if (j % 4 == 2) begin
        s.rd = 1'b1; s.ra = a + 16'(j / 4) + 16'd1;
      end
      steps.push_back(s);
    end
  endfunction

  function automatic void add_idle(input int unsigned n, input logic ca, input logic [15:0] a);
    step_t s;
    for (int unsigned i = 0; i < n; i++) begin
      s = blank(); s.csn = 1'b1; s.ca = ca; s.a = a;
      steps.push_back(s);
    end
  endfunction

  // Drives one nibble per sck cycle and records outputs mid-cycle; also acts as
  // the memory, returning data one rising edge after a sampled rd_en.
  task automatic run_seq();
    step_t o;
    logic pend;
    logic [15:0] pa;
    obs.delete();
    for (int i = 0; i < steps.size(); i++) begin
      @(negedge sck);
      cs_n = steps[i].csn;
      sio_in = steps[i].nib;
      #2;
      o = '0;
      o.wr = wr_en; o.wd = wdata; o.wa = addr;
      o.rd = rd_en; o.ra = addr;
      o.oe = oe; o.sio = sio_out; o.a = addr;
      obs.push_back(o);
      pend = rd_en;
      pa = addr;
      @(posedge sck);
      #1;
      if (pend) rdata = mem[pa];
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cs_n = 1'b1; sio_in = '0; rdata = '0;
    @(negedge sck); #2;
    total++; if (addr !== 16'h0000) begin bad++; $display("FAIL reset_addr got %h want 0000", addr); end
    total++; if (sio_out !== 4'h0) begin bad++; $display("FAIL reset_sio got %h want 0", sio_out); end
    total++; if (oe !== 1'b0) begin bad++; $display("FAIL reset_oe got %b want 0", oe); end
    total++; if ({rd_en, wr_en} !== 2'b00) begin bad++; $display("FAIL reset_strobes got %b want 00", {rd_en, wr_en}); end
    @(posedge sck); #1 rst_n = 1'b1;
  endtask

  task automatic test_write_basic();
    steps.delete();
    add_cmd(8'h02); add_addr(16'h1234); add_write_word(16'h1234, 16'hBEEF);
    add_idle(2, 1'b1, 16'h1235);
    run_seq();
    for (int i = 0; i < steps.size(); i++) begin
      total++; if (obs[i].wr !== steps[i].wr) begin bad++; $display("FAIL write_basic wr_en step %0d got %b want %b", i, obs[i].wr, steps[i].wr); end
      if (steps[i].wr) begin
        total++; if ({obs[i].wa, obs[i].wd} !== {steps[i].wa, steps[i].wd}) begin bad++; $display("FAIL write_basic addr/data step %0d got %h/%h want %h/%h", i, obs[i].wa, obs[i].wd, steps[i].wa, steps[i].wd); end
      end
      total++; if ({obs[i].rd, obs[i].oe} !== 2'b00) begin bad++; $display("FAIL write_basic rd/oe step %0d got %b want 00", i, {obs[i].rd, obs[i].oe}); end
      if (steps[i].ca) begin
        total++; if (obs[i].a !== steps[i].a) begin bad++; $display("FAIL write_basic addr_reg step %0d got %h want %h", i, obs[i].a, steps[i].a); end
      end
    end
  endtask

  task automatic test_read_basic();
    steps.delete();
    mem[16'h1234] = 16'hBEEF;
    add_cmd(8'h03); add_addr(16'h1234); add_read(16'h1234, 1);
    add_idle(1, 1'b1, 16'h1236);
    run_seq();
    for (int i = 0; i < steps.size(); i++) begin
      total++; if ({obs[i].wr, obs[i].rd, obs[i].oe} !== {1'b0, steps[i].rd, steps[i].oe}) begin bad++; $display("FAIL read_basic wr/rd/oe step %0d got %b want %b", i, {obs[i].wr, obs[i].rd, obs[i].oe}, {1'b0, steps[i].rd, steps[i].oe}); end
      if (steps[i].rd) begin
        total++; if (obs[i].ra !== steps[i].ra) begin bad++; $display("FAIL read_basic rd_addr step %0d got %h want %h", i, obs[i].ra, steps[i].ra); end
      end
      if (steps[i].oe) begin
        total++; if (obs[i].sio !== steps[i].sio) begin bad++; $display("FAIL read_basic sio step %0d got %h want %h", i, obs[i].sio, steps[i].sio); end
      end
      if (steps[i].ca) begin
        total++; if (obs[i].a !== steps[i].a) begin bad++; $display("FAIL read_basic addr_reg step %0d got %h want %h", i, obs[i].a, steps[i].a); end
      end
    end
  endtask

  task automatic test_burst_read();
    logic [15:0] a;
    int unsigned n;
    steps.delete();
    for (int t = 0; t < 4; t++) begin
      a = (t == 0) ? 16'hFFFF : 16'($urandom);
      n = (t == 0) ? 3 : $urandom_range(1, 4);
      add_cmd(8'h03); add_addr(a); add_read(a, n);
      add_idle(1, 1'b1, a + 16'(n) + 16'd1);
    end
    run_seq();
    for (int i = 0; i < steps.size(); i++) begin
      total++; if ({obs[i].wr, obs[i].rd, obs[i].oe} !== {1'b0, steps[i].rd, steps[i].oe}) begin bad++; $display("FAIL burst_read wr/rd/oe step %0d got %b want %b", i, {obs[i].wr, obs[i].rd, obs[i].oe}, {1'b0, steps[i].rd, steps[i].oe}); end
      if (steps[i].rd) begin
        total++; if (obs[i].ra !== steps[i].ra) begin bad++; $display("FAIL burst_read rd_addr step %0d got %h want %h", i, obs[i].ra, steps[i].ra); end
      end
      if (steps[i].oe) begin
        total++; if (obs[i].sio !== steps[i].sio) begin bad++; $display("FAIL burst_read sio step %0d got %h want %h", i, obs[i].sio, steps[i].sio); end
      end
      if (steps[i].ca) begin
        total++; if (obs[i].a !== steps[i].a) begin bad++; $display("FAIL burst_read addr_reg step %0d got %h want %h", i, obs[i].a, steps[i].a); end
      end
    end
  endtask

  task automatic test_ignore_cmd();
    logic [7:0] c;
    logic [15:0] a;
    step_t s;
    steps.delete();
    for (int t = 0; t < 3; t++) begin
      c = 8'($urandom);
      if (t == 0 || c == 8'h02 || c == 8'h03) c = 8'h05;
      add_cmd(c);
      for (int k = 0; k < 8; k++) begin s = blank(); steps.push_back(s); end
      add_idle(1, 1'b0, 16'h0000);
      a = 16'($urandom);
      add_cmd(8'h03); add_addr(a); add_read(a, 1);
      add_idle(1, 1'b1, a + 16'd2);
    end
    run_seq();
    for (int i = 0; i < steps.size(); i++) begin
      total++; if ({obs[i].wr, obs[i].rd, obs[i].oe} !== {1'b0, steps[i].rd, steps[i].oe}) begin bad++; $display("FAIL ignore_cmd wr/rd/oe step %0d got %b want %b", i, {obs[i].wr, obs[i].rd, obs[i].oe}, {1'b0, steps[i].rd, steps[i].oe}); end
      if (steps[i].rd) begin
        total++; if (obs[i].ra !== steps[i].ra) begin bad++; $display("FAIL ignore_cmd rd_addr step %0d got %h want %h", i, obs[i].ra, steps[i].ra); end
      end
      if (steps[i].oe) begin
        total++; if (obs[i].sio !== steps[i].sio) begin bad++; $display("FAIL ignore_cmd sio step %0d got %h want %h", i, obs[i].sio, steps[i].sio); end
      end
      if (steps[i].ca) begin
        total++; if (obs[i].a !== steps[i].a) begin bad++; $display("FAIL ignore_cmd addr_reg step %0d got %h want %h", i, obs[i].a, steps[i].a); end
      end
    end
  endtask

  // Covers partial-word discard and back-to-back word streams, including
  // address wrap from 0xFFFE.
  task automatic test_back_to_back();
    logic [15:0] a;
    int unsigned n;
    step_t s;
    steps.delete();
    a = 16'($urandom);
    add_cmd(8'h02); add_addr(a);
    s = blank(); steps.push_back(s);
    s = blank(); steps.push_back(s);
    add_idle(1, 1'b1, a);
    add_cmd(8'h02); add_addr(16'h0010); add_write_word(16'h0010, 16'h1234);
    add_idle(1, 1'b1, 16'h0011);
    for (int t = 0; t < 3; t++) begin
      a = (t == 0) ? 16'hFFFE : 16'($urandom);
      n = $urandom_range(2, 4);
      add_cmd(8'h02); add_addr(a);
      for (int unsigned k = 0; k < n; k++) add_write_word(a + 16'(k), 16'($urandom));
      add_idle(1, 1'b1, a + 16'(n));
    end
    run_seq();
    for (int i = 0; i < steps.size(); i++) begin
      total++; if (obs[i].wr !== steps[i].wr) begin bad++; $display("FAIL back_to_back wr_en step %0d got %b want %b", i, obs[i].wr, steps[i].wr); end
      if (steps[i].wr) begin
        total++; if ({obs[i].wa, obs[i].wd} !== {steps[i].wa, steps[i].wd}) begin bad++; $display("FAIL back_to_back addr/data step %0d got %h/%h want %h/%h", i, obs[i].wa, obs[i].wd, steps[i].wa, steps[i].wd); end
      end
      total++; if ({obs[i].rd, obs[i].oe} !== 2'b00) begin bad++; $display("FAIL back_to_back rd/oe step %0d got %b want 00", i, {obs[i].rd, obs[i].oe}); end
      if (steps[i].ca) begin
        total++; if (obs[i].a !== steps[i].a) begin bad++; $display("FAIL back_to_back addr_reg step %0d got %h want %h", i, obs[i].a, steps[i].a); end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    logic [15:0] a;
    steps.delete();
    a = 16'($urandom);
    mem[a + 16'd1] = 16'h9ABC;
    add_cmd(8'h03); add_addr(a); add_read(a, 2);
    for (int k = 0; k < 3; k++) void'(steps.pop_back());
    run_seq();
    @(negedge sck);
    rst_n = 1'b0;
    #2;
    total++; if (sio_out !== 4'h0) begin bad++; $display("FAIL reset_mid sio got %h want 0", sio_out); end
    total++; if (oe !== 1'b0) begin bad++; $display("FAIL reset_mid oe got %b want 0", oe); end
    total++; if ({rd_en, wr_en} !== 2'b00) begin bad++; $display("FAIL reset_mid strobes got %b want 00", {rd_en, wr_en}); end
    total++; if (addr !== 16'h0000) begin bad++; $display("FAIL reset_mid addr got %h want 0000", addr); end
    cs_n = 1'b1;
    @(posedge sck); #1 rst_n = 1'b1;
    steps.delete();
    a = 16'($urandom);
    add_cmd(8'h03); add_addr(a); add_read(a, 2);
    add_idle(1, 1'b1, a + 16'd3);
    run_seq();
    for (int i = 0; i < steps.size(); i++) begin
      total++; if ({obs[i].wr, obs[i].rd, obs[i].oe} !== {1'b0, steps[i].rd, steps[i].oe}) begin bad++; $display("FAIL reset_mid_next wr/rd/oe step %0d got %b want %b", i, {obs[i].wr, obs[i].rd, obs[i].oe}, {1'b0, steps[i].rd, steps[i].oe}); end
      if (steps[i].rd) begin
        total++; if (obs[i].ra !== steps[i].ra) begin bad++; $display("FAIL reset_mid_next rd_addr step %0d got %h want %h", i, obs[i].ra, steps[i].ra); end
      end
      if (steps[i].oe) begin
        total++; if (obs[i].sio !== steps[i].sio) begin bad++; $display("FAIL reset_mid_next sio step %0d got %h want %h", i, obs[i].sio, steps[i].sio); end
      end
      if (steps[i].ca) begin
        total++; if (obs[i].a !== steps[i].a) begin bad++; $display("FAIL reset_mid_next addr_reg step %0d got %h want %h", i, obs[i].a, steps[i].a); end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
    test_reset();
    test_write_basic();
    test_read_basic();
    test_burst_read();
    test_ignore_cmd();
    test_back_to_back();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
